// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 encodings and FSM states.
package lsu_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } lsu_state_e;

    // Stores only exist as SB/SH/SW; loads additionally allow the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: little-endian extract/extend for loads, lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = word[{addr[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = word;
        endcase
    end

    // Untouched lanes pass straight through so the read-modify-write preserves them.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B:    store_word[{addr, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed RV32I loads/stores onto a word-addressed memory.
//   state | meaning
//   IDLE  | ready for a request; errors answered from here
//   RD    | memory read issued
//   CAP   | read data present; extract load or merge store lanes
//   WR    | memory write of the buffered word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 21
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_rw,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_din,
    input  logic [XLEN-1:0] mem_dout
);

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    lsu_state_e      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] wbuf;

    logic            accept;
    logic            misaligned;
    logic            out_of_range;
    logic            req_err;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr[31:2] >= MEM_LIMIT);
        req_err      = misaligned | out_of_range | ~f3_legal(req_we, req_funct3);
    end

    lsu_lane_align u_lane_align (
        .word       (mem_dout),
        .addr       (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_val),
        .store_word (merged)
    );

    // Gating with ~rst guarantees no write can land on a reset edge.
    assign mem_en   = ~rst & ((state == RD) | (state == WR));
    assign mem_rw   = ~rst & (state == WR);
    assign mem_addr = mem_en ? {2'b00, addr_q[31:2]} : '0;
    assign mem_din  = mem_rw ? wbuf : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wbuf       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            wbuf  <= req_wdata;
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (we_q) begin
                        wbuf  <= merged;
                        state <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_val;
                        state      <= IDLE;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
